// File: rtl/alu_issue_pkg.sv
// Shared widths, operand-select encodings, ALU one-hot bit positions and
// packed views of the bundled decode/forwarding buses.
package alu_issue_pkg;
  localparam int XLEN    = 32;
  localparam int ALU_W   = 12;
  localparam int ID_WB_W = 7;
  localparam int FWD_W   = 38;
  localparam int REG_W   = 37;

  localparam logic [1:0] SRC1_RS    = 2'b00;
  localparam logic [1:0] SRC1_SHAMT = 2'b01;
  localparam logic [1:0] SRC1_PC    = 2'b10;
  localparam logic [1:0] SRC1_ZERO  = 2'b11;

  localparam logic [1:0] SRC2_RT    = 2'b00;
  localparam logic [1:0] SRC2_SIMM  = 2'b01;
  localparam logic [1:0] SRC2_ZIMM  = 2'b10;
  localparam logic [1:0] SRC2_EIGHT = 2'b11;

  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  typedef struct packed {
    logic       we;
    logic       is_load;
    logic [4:0] waddr;
  } wb_t;

  typedef struct packed {
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
  } fwd_t;

  typedef struct packed {
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } reg_t;
endpackage

// File: rtl/alu_issue_fwd_mux.sv
// Priority bypass for one source register: r0, then EX result, then MEM,
// then WB, else the register-file read value.
module fwd_mux
  import alu_issue_pkg::*;
(
  input  logic [4:0]       addr,
  input  logic [XLEN-1:0]  rf_data,
  input  logic             ex_en,
  input  logic [4:0]       ex_waddr,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [FWD_W-1:0] mem_fwd,
  input  logic [FWD_W-1:0] wb_fwd,
  output logic [XLEN-1:0]  value
);
  fwd_t mem_s, wb_s;
  assign mem_s = mem_fwd;
  assign wb_s  = wb_fwd;

  always_comb begin
    value = rf_data;
    if (addr == 5'd0)                         value = '0;
    else if (ex_en && ex_waddr == addr)       value = ex_result;
    else if (mem_s.we && mem_s.waddr == addr) value = mem_s.wdata;
    else if (wb_s.we && wb_s.waddr == addr)   value = wb_s.wdata;
  end
endmodule

// File: rtl/alu_issue.sv
// Decode->execute issue register: forwards operands, selects ALU sources,
// detects load-use hazards and applies flush/stall/bubble control.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [ALU_W-1:0]     id_alu_control,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic [15:0]          id_imm,
  input  logic [3:0]           id_src_sel,
  input  logic [ID_WB_W-1:0]   id_wb,
  input  logic [XLEN-1:0]      ex_result,
  input  logic [FWD_W-1:0]     mem_fwd,
  input  logic [FWD_W-1:0]     wb_fwd,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc,
  output logic [ALU_W-1:0]     alu_control,
  output logic [XLEN-1:0]      alu_src1,
  output logic [XLEN-1:0]      alu_src2,
  output logic [ID_WB_W-1:0]   ex_wb,
  output logic                 stall_req
);
  logic             ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]  ex_pc_q, ex_pc_d;
  logic [ALU_W-1:0] alu_control_q, alu_control_d;
  logic [XLEN-1:0]  alu_src1_q, alu_src1_d;
  logic [XLEN-1:0]  alu_src2_q, alu_src2_d;
  wb_t              ex_wb_q, ex_wb_d;

  reg_t            rs_s, rt_s;
  logic [1:0]      sel1, sel2;
  logic [XLEN-1:0] rs_val, rt_val, src1, src2;
  logic            ex_fwd_en, rs_used, rt_used;

  assign rs_s = id_rs;
  assign rt_s = id_rt;
  assign sel1 = id_src_sel[3:2];
  assign sel2 = id_src_sel[1:0];

  // A load's data is not ready in EX, so only non-load results are bypassed.
  assign ex_fwd_en = ex_valid_q & ex_wb_q.we & ~ex_wb_q.is_load;

  fwd_mux u_fwd_rs (
    .addr(rs_s.addr), .rf_data(rs_s.data), .ex_en(ex_fwd_en),
    .ex_waddr(ex_wb_q.waddr), .ex_result(ex_result),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .value(rs_val)
  );

  fwd_mux u_fwd_rt (
    .addr(rt_s.addr), .rf_data(rt_s.data), .ex_en(ex_fwd_en),
    .ex_waddr(ex_wb_q.waddr), .ex_result(ex_result),
    .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .value(rt_val)
  );

  always_comb begin
    case (sel1)
      SRC1_RS:    src1 = rs_val;
      SRC1_SHAMT: src1 = {27'd0, id_imm[10:6]};
      SRC1_PC:    src1 = id_pc;
      default:    src1 = '0;
    endcase
    case (sel2)
      SRC2_RT:    src2 = rt_val;
      SRC2_SIMM:  src2 = {{16{id_imm[15]}}, id_imm};
      SRC2_ZIMM:  src2 = {16'd0, id_imm};
      default:    src2 = 32'd8;
    endcase
  end

  assign rs_used   = (sel1 == SRC1_RS);
  assign rt_used   = (sel2 == SRC2_RT);
  assign stall_req = id_valid & ex_valid_q & ex_wb_q.we & ex_wb_q.is_load &
                     (ex_wb_q.waddr != 5'd0) &
                     ((rs_used & (rs_s.addr == ex_wb_q.waddr)) |
                      (rt_used & (rt_s.addr == ex_wb_q.waddr)));

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    alu_control_d = alu_control_q;
    alu_src1_d    = alu_src1_q;
    alu_src2_d    = alu_src2_q;
    ex_wb_d       = ex_wb_q;
    if (flush || (!stall && (stall_req || !id_valid))) begin
      ex_valid_d    = 1'b0;
      ex_pc_d       = '0;
      alu_control_d = '0;
      alu_src1_d    = '0;
      alu_src2_d    = '0;
      ex_wb_d       = '0;
    end else if (!stall) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = id_pc;
      alu_control_d = id_alu_control;
      alu_src1_d    = src1;
      alu_src2_d    = src2;
      ex_wb_d       = id_wb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      alu_control_q <= '0;
      alu_src1_q    <= '0;
      alu_src2_q    <= '0;
      ex_wb_q       <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      alu_control_q <= alu_control_d;
      alu_src1_q    <= alu_src1_d;
      alu_src2_q    <= alu_src2_d;
      ex_wb_q       <= ex_wb_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign alu_control = alu_control_q;
  assign alu_src1    = alu_src1_q;
  assign alu_src2    = alu_src2_q;
  assign ex_wb       = ex_wb_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed scenarios then randomized traffic, checked against a behavioural
// model of the issue register.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_pc, ex_result;
  logic [11:0] id_alu_control;
  logic [36:0] id_rs, id_rt;
  logic [15:0] id_imm;
  logic [3:0]  id_src_sel;
  logic [6:0]  id_wb;
  logic [37:0] mem_fwd, wb_fwd;
  logic        ex_valid, stall_req;
  logic [31:0] ex_pc, alu_src1, alu_src2;
  logic [11:0] alu_control;
  logic [6:0]  ex_wb;

  int nchk = 0;
  int nfail = 0;

  // model state of the output register
  logic        m_valid;
  logic [31:0] m_pc, m_src1, m_src2;
  logic [11:0] m_ctrl;
  logic [6:0]  m_wb;
  logic        n_valid;
  logic [31:0] n_pc, n_src1, n_src2;
  logic [11:0] n_ctrl;
  logic [6:0]  n_wb;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_alu_control(id_alu_control), .id_rs(id_rs), .id_rt(id_rt),
    .id_imm(id_imm), .id_src_sel(id_src_sel), .id_wb(id_wb),
    .ex_result(ex_result), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .ex_wb(ex_wb), .stall_req(stall_req)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 0;
    if (m_valid && m_wb[6] && !m_wb[5] && m_wb[4:0] == a) return ex_result;
    if (mem_fwd[37] && mem_fwd[36:32] == a) return mem_fwd[31:0];
    if (wb_fwd[37] && wb_fwd[36:32] == a) return wb_fwd[31:0];
    return rf;
  endfunction

  function automatic logic model_stall();
    logic [4:0] la;
    la = m_wb[4:0];
    if (!(id_valid && m_valid && m_wb[6] && m_wb[5] && la != 0)) return 0;
    return (id_src_sel[3:2] == 0 && id_rs[36:32] == la) ||
           (id_src_sel[1:0] == 0 && id_rt[36:32] == la);
  endfunction

  task automatic model_next();
    logic bubble;
    bubble = 0;
    {n_valid, n_pc, n_ctrl, n_src1, n_src2, n_wb} = {m_valid, m_pc, m_ctrl, m_src1, m_src2, m_wb};
    if (rst || flush) bubble = 1;
    else if (stall) bubble = 0;
    else if (model_stall() || !id_valid) bubble = 1;
    else begin
      n_valid = 1; n_pc = id_pc; n_ctrl = id_alu_control; n_wb = id_wb;
      case (id_src_sel[3:2])
        0: n_src1 = fwd(id_rs[36:32], id_rs[31:0]);
        1: n_src1 = 32'(id_imm[10:6]);
        2: n_src1 = id_pc;
        default: n_src1 = 0;
      endcase
      case (id_src_sel[1:0])
        0: n_src2 = fwd(id_rt[36:32], id_rt[31:0]);
        1: n_src2 = 32'($signed(id_imm));
        2: n_src2 = 32'(id_imm);
        default: n_src2 = 8;
      endcase
    end
    if (bubble) {n_valid, n_pc, n_ctrl, n_src1, n_src2, n_wb} = '0;
  endtask

  // one clock: check combinational hazard, advance model, check registers
  task automatic step();
    #1;
    chk("stall_req", 32'(stall_req), 32'(model_stall()));
    model_next();
    @(posedge clk);
    {m_valid, m_pc, m_ctrl, m_src1, m_src2, m_wb} = {n_valid, n_pc, n_ctrl, n_src1, n_src2, n_wb};
    #1;
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_pc", ex_pc, m_pc);
    chk("alu_control", 32'(alu_control), 32'(m_ctrl));
    chk("alu_src1", alu_src1, m_src1);
    chk("alu_src2", alu_src2, m_src2);
    chk("ex_wb", 32'(ex_wb), 32'(m_wb));
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_alu_control = 0;
    id_rs = 0; id_rt = 0; id_imm = 0; id_src_sel = 4'b1111; id_wb = 0;
    ex_result = 0; mem_fwd = 0; wb_fwd = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [6:0] wb,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] sel);
    idle();
    id_valid = 1; id_pc = pc; id_alu_control = 12'h800; id_wb = wb;
    id_rs = {rs, 32'h1111_0000 + 32'(rs)}; id_rt = {rt, 32'h2222_0000 + 32'(rt)};
    id_src_sel = sel; id_imm = 16'h0040;
  endtask

  initial begin
    m_valid = 0; m_pc = 0; m_ctrl = 0; m_src1 = 0; m_src2 = 0; m_wb = 0;
    idle();
    // reset with garbage inputs
    rst = 1; id_valid = 1; id_pc = 32'hDEAD_BEEF; id_alu_control = 12'h0F0; id_wb = 7'h7F;
    id_src_sel = 4'b0000; stall = 1;
    step();
    chk("reset_valid", 32'(ex_valid), 32'd0);
    idle(); step();

    // EX add->r5 bypassed into rs
    issue(32'h100, {2'b10, 5'd5}, 5'd1, 5'd2, 4'b0000); step();
    issue(32'h104, {2'b10, 5'd9}, 5'd5, 5'd2, 4'b0000); ex_result = 32'h0000_1234;
    step();
    chk("ex_fwd_rs", alu_src1, 32'h0000_1234);

    // EX lw->r3 with rt=r3 used: hazard and bubble
    issue(32'h200, {2'b11, 5'd3}, 5'd1, 5'd2, 4'b0000); step();
    issue(32'h204, {2'b10, 5'd4}, 5'd1, 5'd3, 4'b0000);
    #1 chk("load_use_req", 32'(stall_req), 32'd1);
    step();
    chk("load_use_bubble", 32'(ex_valid), 32'd0);
    chk("load_use_ctrl", 32'(alu_control), 32'd0);
    step(); // re-presented instruction now issues

    // MEM beats WB; r0 always zero
    issue(32'h300, {2'b10, 5'd8}, 5'd7, 5'd2, 4'b0000);
    mem_fwd = {1'b1, 5'd7, 32'h0000_AAAA}; wb_fwd = {1'b1, 5'd7, 32'h0000_BBBB};
    step();
    chk("mem_over_wb", alu_src1, 32'h0000_AAAA);
    issue(32'h304, {2'b10, 5'd8}, 5'd0, 5'd2, 4'b0000);
    wb_fwd = {1'b1, 5'd0, 32'h0000_BBBB};
    step();
    chk("r0_zero", alu_src1, 32'd0);

    // immediates
    issue(32'h400, 7'h41, 5'd1, 5'd2, 4'b1101); id_imm = 16'hFFF0; step();
    chk("simm", alu_src2, 32'hFFFF_FFF0);
    issue(32'h404, 7'h41, 5'd1, 5'd2, 4'b1110); id_imm = 16'hFFF0; step();
    chk("zimm", alu_src2, 32'h0000_FFF0);
    issue(32'h408, 7'h41, 5'd1, 5'd2, 4'b0111); id_imm = 16'h0140; step();
    chk("shamt", alu_src1, 32'd5);
    chk("eight", alu_src2, 32'd8);

    // stall+flush -> bubble
    issue(32'h500, 7'h42, 5'd1, 5'd2, 4'b1010); step();
    stall = 1; flush = 1; step();
    chk("flush_wins", 32'(ex_valid), 32'd0);
    // stall holds for three cycles
    issue(32'h600, 7'h43, 5'd1, 5'd2, 4'b1010); step();
    issue(32'h700, 7'h44, 5'd6, 5'd6, 4'b0000); stall = 1;
    for (int i = 0; i < 3; i++) step();
    chk("stall_hold_pc", ex_pc, 32'h600);
    // rst during stall
    rst = 1; step();
    chk("rst_over_stall", ex_pc, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 15) == 0);
      stall = ($urandom_range(0, 5) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = $urandom;
      id_alu_control = 12'(1 << $urandom_range(0, 11));
      id_rs = {5'($urandom_range(0, 7)), 32'($urandom)};
      id_rt = {5'($urandom_range(0, 7)), 32'($urandom)};
      id_imm = 16'($urandom);
      id_src_sel = 4'($urandom);
      id_wb = {2'($urandom), 5'($urandom_range(0, 7))};
      ex_result = $urandom;
      mem_fwd = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
      wb_fwd  = {1'($urandom), 5'($urandom_range(0, 7)), 32'($urandom)};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
